// File: rtl/sdram_test_pkg.sv
// rtl/sdram_test_pkg.sv - state codes, pattern modes and LFSR taps for the SDRAM pattern tester
package sdram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_FINISH  = 3'd5
  } testState_t;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_ADDR  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_WALK  = 2'd3
  } patMode_t;

  // Galois right-shift masks for maximal-length sequences
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

  function automatic logic [31:0] lfsrTaps(input int width);
    case (width)
      8:       return {24'd0, LFSR_TAPS_8};
      32:      return LFSR_TAPS_32;
      default: return {16'd0, LFSR_TAPS_16};
    endcase
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// rtl/sdram_pattern_gen.sv - data pattern generator; load seeds it, advance steps to the next word
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] seed,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] wordAddr,
  output logic [DATA_W-1:0] word
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsrTaps(DATA_W));
  localparam int WALK_W = $clog2(DATA_W);

  logic [DATA_W-1:0] fixedVal;
  logic [DATA_W-1:0] lfsr;
  logic [WALK_W-1:0] walkIdx;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fixedVal <= '0;
      lfsr     <= DATA_W'(1);
      walkIdx  <= '0;
    end else if (load) begin
      fixedVal <= seed;
      lfsr     <= (seed == '0) ? DATA_W'(1) : seed;
      walkIdx  <= '0;
    end else if (advance) begin
      lfsr    <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
      walkIdx <= walkIdx + 1'b1;
    end
  end

  always_comb begin
    word = '0;
    case (patMode_t'(mode))
      MODE_FIXED: word = fixedVal;
      MODE_ADDR:  word = DATA_W'(wordAddr);
      MODE_LFSR:  word = lfsr;
      MODE_WALK:  word = DATA_W'(1) << walkIdx;
      default:    word = '0;
    endcase
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// rtl/sdram_pattern_tester.sv - writes pattern bursts through the SDRAM host port, reads back and checks
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int                 ADDR_W     = 23,
  parameter int                 DATA_W     = 16,
  parameter int                 BURST_LEN  = 128,
  parameter int                 NUM_BURSTS = 4,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter int unsigned        TIMEOUT    = 65535
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                START,
  input  logic [1:0]          MODE,
  input  logic [DATA_W-1:0]   SEED,
  output logic [ADDR_W-1:0]   ADDR,
  output logic                WR,
  output logic                RD,
  output logic [8:0]          LENGTH,
  output logic [DATA_W-1:0]   DATAIN,
  output logic [DATA_W/8-1:0] DM,
  input  logic                IN_REQ,
  input  logic [DATA_W-1:0]   DATAOUT,
  input  logic                OUT_VALID,
  input  logic                DONE,
  output logic                BUSY,
  output logic                PASS,
  output logic                FAIL,
  output logic                TIMED_OUT,
  output logic [15:0]         ERR_COUNT,
  output logic [ADDR_W-1:0]   ERR_ADDR,
  output logic [DATA_W-1:0]   ERR_EXP,
  output logic [DATA_W-1:0]   ERR_GOT,
  output logic [2:0]          ST
);

  localparam int BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  testState_t state, nextState;
  logic [ADDR_W-1:0]  addrReg, wrIdx, rdIdx;
  logic [BURST_W-1:0] burstIdx;
  logic [31:0]        toCnt;
  logic [DATA_W-1:0]  seedReg, wrWord, chkWord;
  logic [1:0]         modeReg;
  logic               passReg, failReg, timedOut;
  logic [15:0]        errCount;
  logic [ADDR_W-1:0]  errAddr;
  logic [DATA_W-1:0]  errExp, errGot;
  logic               startAccept, inWait, lastBurst, timeoutHit;

  assign startAccept = (state == ST_IDLE) && START;
  assign inWait      = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
  assign lastBurst   = (burstIdx == BURST_W'(NUM_BURSTS - 1));
  assign timeoutHit  = inWait && !DONE && (toCnt == 32'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    WR        = 1'b0;
    RD        = 1'b0;
    BUSY      = 1'b1;
    DATAIN    = '0;
    case (state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (START) nextState = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        WR        = 1'b1;
        DATAIN    = wrWord;
        nextState = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        WR     = 1'b1;
        DATAIN = wrWord;
        if (DONE)            nextState = lastBurst ? ST_RD_REQ : ST_WR_REQ;
        else if (timeoutHit) nextState = ST_FINISH;
      end
      ST_RD_REQ: begin
        RD        = 1'b1;
        nextState = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        RD = 1'b1;
        if (DONE)            nextState = lastBurst ? ST_FINISH : ST_RD_REQ;
        else if (timeoutHit) nextState = ST_FINISH;
      end
      ST_FINISH: begin
        BUSY      = 1'b0;
        nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      addrReg  <= '0;
      burstIdx <= '0;
      wrIdx    <= '0;
      rdIdx    <= '0;
      toCnt    <= '0;
      seedReg  <= '0;
      modeReg  <= '0;
      passReg  <= 1'b0;
      failReg  <= 1'b0;
      timedOut <= 1'b0;
      errCount <= '0;
      errAddr  <= '0;
      errExp   <= '0;
      errGot   <= '0;
    end else begin
      if (startAccept) begin
        addrReg  <= START_ADDR;
        burstIdx <= '0;
        wrIdx    <= '0;
        rdIdx    <= '0;
        seedReg  <= SEED;
        modeReg  <= MODE;
        passReg  <= 1'b0;
        failReg  <= 1'b0;
        timedOut <= 1'b0;
        errCount <= '0;
        errAddr  <= '0;
        errExp   <= '0;
        errGot   <= '0;
      end
      if ((state == ST_WR_REQ) || (state == ST_RD_REQ)) toCnt <= '0;
      if (inWait) toCnt <= toCnt + 32'd1;
      if ((state == ST_WR_WAIT) && IN_REQ) wrIdx <= wrIdx + 1'b1;
      if ((state == ST_RD_WAIT) && OUT_VALID) begin
        rdIdx <= rdIdx + 1'b1;
        if (DATAOUT != chkWord) begin
          if (errCount != 16'hFFFF) errCount <= errCount + 16'd1;
          if (errCount == '0) begin
            errAddr <= addrReg + rdIdx;
            errExp  <= chkWord;
            errGot  <= DATAOUT;
          end
        end
      end
      // Word indices restart per burst; the base moves on, back to START_ADDR for readback
      if (inWait && DONE) begin
        wrIdx    <= '0;
        rdIdx    <= '0;
        burstIdx <= lastBurst ? '0 : burstIdx + 1'b1;
        addrReg  <= (lastBurst && (state == ST_WR_WAIT)) ? START_ADDR
                                                          : addrReg + ADDR_W'(BURST_LEN);
      end else if (timeoutHit) begin
        timedOut <= 1'b1;
        failReg  <= 1'b1;
      end
      if (state == ST_FINISH) begin
        passReg <= (errCount == '0) && !timedOut;
        failReg <= !((errCount == '0) && !timedOut);
      end
    end
  end

  sdram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wrGen (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .load     (startAccept),
    .advance  ((state == ST_WR_WAIT) && IN_REQ),
    .seed     (SEED),
    .mode     (modeReg),
    .wordAddr (addrReg + wrIdx),
    .word     (wrWord)
  );

  sdram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) chkGen (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .load     ((state == ST_RD_REQ) && (burstIdx == '0)),
    .advance  ((state == ST_RD_WAIT) && OUT_VALID),
    .seed     (seedReg),
    .mode     (modeReg),
    .wordAddr (addrReg + rdIdx),
    .word     (chkWord)
  );

  assign ADDR      = addrReg;
  assign LENGTH    = 9'(BURST_LEN);
  assign DM        = '0;
  assign PASS      = passReg;
  assign FAIL      = failReg;
  assign TIMED_OUT = timedOut;
  assign ERR_COUNT = errCount;
  assign ERR_ADDR  = errAddr;
  assign ERR_EXP   = errExp;
  assign ERR_GOT   = errGot;
  assign ST        = state;

endmodule
